// File: rtl/i2c_transaction_sequencer_if.sv
// Groups the command, bit-op and response signals shared by a host, the transaction sequencer and the I2C bit engine.
// Signal suffixes are from the sequencer's point of view. The sequencer connects through the master modport.
interface i2c_transaction_sequencer_if #(
  parameter int REG_ADDR_BYTES = 2,
  parameter int MAX_DATA_BYTES = 2,
  parameter int LEN_W          = $clog2(MAX_DATA_BYTES + 1)
);
  logic                        cmd_valid_i;
  logic                        cmd_ready_o;
  logic                        cmd_rnw_i;
  logic [6:0]                  cmd_dev_addr_i;
  logic [8*REG_ADDR_BYTES-1:0] cmd_reg_addr_i;
  logic [LEN_W-1:0]            cmd_len_i;
  logic [8*MAX_DATA_BYTES-1:0] cmd_wdata_i;
  logic                        op_valid_o;
  logic                        op_ready_i;
  logic [2:0]                  op_o;
  logic                        res_valid_i;
  logic                        res_bit_i;
  logic                        rsp_valid_o;
  logic                        rsp_error_o;
  logic [8*MAX_DATA_BYTES-1:0] rsp_rdata_o;

  modport master (
    input  cmd_valid_i, cmd_rnw_i, cmd_dev_addr_i, cmd_reg_addr_i, cmd_len_i, cmd_wdata_i,
    input  op_ready_i, res_valid_i, res_bit_i,
    output cmd_ready_o, op_valid_o, op_o, rsp_valid_o, rsp_error_o, rsp_rdata_o
  );

  modport slave (
    output cmd_valid_i, cmd_rnw_i, cmd_dev_addr_i, cmd_reg_addr_i, cmd_len_i, cmd_wdata_i,
    output op_ready_i, res_valid_i, res_bit_i,
    input  cmd_ready_o, op_valid_o, op_o, rsp_valid_o, rsp_error_o, rsp_rdata_o
  );
endinterface

// File: rtl/i2c_transaction_sequencer.sv
// Compiles one I2C register read/write command into a stream of bit-level ops for the I2C engine,
// aborts on slave NACK and reassembles read data into a right-aligned response word.
module i2c_transaction_sequencer #(
  parameter int REG_ADDR_BYTES = 2,
  parameter int MAX_DATA_BYTES = 2,
  parameter int LEN_W          = $clog2(MAX_DATA_BYTES + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  i2c_transaction_sequencer_if.master bus
);
  localparam int RW = 8 * REG_ADDR_BYTES;
  localparam int DW = 8 * MAX_DATA_BYTES;

  localparam logic [2:0] OP_RX    = 3'd2;
  localparam logic [2:0] OP_RXACK = 3'd3;
  localparam logic [2:0] OP_RS    = 3'd4;
  localparam logic [2:0] OP_ST    = 3'd5;
  localparam logic [2:0] OP_SP    = 3'd6;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_DEV_W  = 4'd2;
  localparam logic [3:0] S_REG    = 4'd3;
  localparam logic [3:0] S_WDATA  = 4'd4;
  localparam logic [3:0] S_RSTART = 4'd5;
  localparam logic [3:0] S_DEV_R  = 4'd6;
  localparam logic [3:0] S_RDATA  = 4'd7;
  localparam logic [3:0] S_STOP   = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [3:0]       bit_q, bit_d;
  logic [3:0]       byte_q, byte_d;
  logic             wait_q, wait_d;
  logic             rnw_q, rnw_d;
  logic [6:0]       dev_q, dev_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [RW-1:0]    reg_q, reg_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             rsp_q, rsp_d;

  logic [2:0]       op;
  logic             op_active;
  logic [3:0]       phase_bytes;
  logic             last_byte;
  logic             op_fire, res_fire, is_rx_op;
  logic [LEN_W-1:0] len_c;

  // NOTE: every signal driven from always_comb gets a default first, so no latch is ever inferred.
  always_comb begin
    op          = OP_SP;
    op_active   = 1'b1;
    phase_bytes = 4'd1;
    if (state_q == S_REG) begin
      phase_bytes = 4'(REG_ADDR_BYTES);
    end else if (state_q == S_WDATA || state_q == S_RDATA) begin
      phase_bytes = 4'(len_q);
    end
    last_byte = (byte_q == phase_bytes - 4'd1);
    case (state_q)
      S_START:          op = OP_ST;
      S_RSTART:         op = OP_RS;
      S_STOP:           op = OP_SP;
      S_DEV_W, S_DEV_R: begin
        if (bit_q == 4'd8)      op = OP_RXACK;
        else if (bit_q == 4'd7) op = {2'b00, (state_q == S_DEV_R)};
        else                    op = {2'b00, dev_q[3'd6 - bit_q[2:0]]};
      end
      S_REG:   op = (bit_q == 4'd8) ? OP_RXACK : {2'b00, reg_q[RW-1]};
      S_WDATA: op = (bit_q == 4'd8) ? OP_RXACK : {2'b00, wdata_q[DW-1]};
      // Master ACKs every read byte except the last, which it NACKs.
      S_RDATA: op = (bit_q == 4'd8) ? {2'b00, last_byte} : OP_RX;
      default: op_active = 1'b0;
    endcase
  end

  assign is_rx_op = (op == OP_RX) || (op == OP_RXACK);
  assign op_fire  = op_active && !wait_q && bus.op_ready_i;
  assign res_fire = wait_q && bus.res_valid_i;
  assign len_c    = (bus.cmd_len_i > LEN_W'(MAX_DATA_BYTES)) ? LEN_W'(MAX_DATA_BYTES) : bus.cmd_len_i;

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    wait_d  = wait_q;
    rnw_d   = rnw_q;
    dev_d   = dev_q;
    len_d   = len_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rsp_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.cmd_valid_i) begin
        state_d = S_START;
        bit_d   = '0;
        byte_d  = '0;
        wait_d  = 1'b0;
        rnw_d   = bus.cmd_rnw_i;
        dev_d   = bus.cmd_dev_addr_i;
        len_d   = len_c;
        reg_d   = bus.cmd_reg_addr_i;
        // Left-align the payload so the first byte to send always sits at the MSB.
        wdata_d = bus.cmd_wdata_i << (8 * (MAX_DATA_BYTES - int'(len_c)));
        rdata_d = '0;
        err_d   = 1'b0;
      end
    end else if (op_fire && is_rx_op) begin
      wait_d = 1'b1;
    end else if (op_fire || res_fire) begin
      wait_d = 1'b0;
      if (state_q == S_START) begin
        state_d = S_DEV_W;
      end else if (state_q == S_RSTART) begin
        state_d = S_DEV_R;
      end else if (state_q == S_STOP) begin
        state_d = S_IDLE;
        rsp_d   = 1'b1;
      end else if (op == OP_RXACK && bus.res_bit_i) begin
        err_d   = 1'b1;
        state_d = S_STOP;
      end else begin
        if (op == OP_RX)                       rdata_d = {rdata_q[DW-2:0], bus.res_bit_i};
        if (state_q == S_REG   && bit_q != 4'd8) reg_d   = reg_q << 1;
        if (state_q == S_WDATA && bit_q != 4'd8) wdata_d = wdata_q << 1;
        if (bit_q != 4'd8) begin
          bit_d = bit_q + 4'd1;
        end else begin
          bit_d = '0;
          if (!last_byte) begin
            byte_d = byte_q + 4'd1;
          end else begin
            byte_d = '0;
            case (state_q)
              S_DEV_W: state_d = S_REG;
              S_REG:   state_d = (len_q == '0) ? S_STOP : (rnw_q ? S_RSTART : S_WDATA);
              S_DEV_R: state_d = S_RDATA;
              default: state_d = S_STOP;
            endcase
          end
        end
      end
    end
  end

  // NOTE: registers are written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      wait_q  <= 1'b0;
      rnw_q   <= 1'b0;
      dev_q   <= '0;
      len_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rsp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      wait_q  <= wait_d;
      rnw_q   <= rnw_d;
      dev_q   <= dev_d;
      len_q   <= len_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.cmd_ready_o = (state_q == S_IDLE);
  assign bus.op_valid_o  = op_active && !wait_q;
  assign bus.op_o        = op;
  assign bus.rsp_valid_o = rsp_q;
  assign bus.rsp_error_o = err_q;
  assign bus.rsp_rdata_o = rdata_q;
endmodule

// File: tb/tb_i2c_transaction_sequencer.sv
// Directed bench: drives commands, plays the bit-level I2C engine and compares the op stream and responses.
module tb_i2c_transaction_sequencer;
  localparam int OP_TX0 = 0, OP_TX1 = 1, OP_RX = 2, OP_RXACK = 3, OP_RS = 4, OP_ST = 5, OP_SP = 6;

  logic clk;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  i2c_transaction_sequencer_if #(.REG_ADDR_BYTES(2), .MAX_DATA_BYTES(2)) if_a ();
  i2c_transaction_sequencer_if #(.REG_ADDR_BYTES(1), .MAX_DATA_BYTES(2)) if_b ();

  i2c_transaction_sequencer #(.REG_ADDR_BYTES(2), .MAX_DATA_BYTES(2)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_a.master));
  i2c_transaction_sequencer #(.REG_ADDR_BYTES(1), .MAX_DATA_BYTES(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(if_b.master));

  always #5 clk = ~clk;

  int          ops_q[$];
  int          exp_q[$];
  bit          got_rsp;
  logic        got_err;
  logic [15:0] got_rdata;
  int          rsp_lat;
  logic        rdy_at_rsp;
  int          stall_viol;
  int          wait_viol;
  bit          first_ok;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_tx_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(int'(b[i]));
    exp_q.push_back(OP_RXACK);
  endtask

  // Reference op stream derived from the protocol description, independent of the DUT's FSM.
  task automatic build_exp(input bit rnw, input logic [6:0] dev, input logic [31:0] regv, input int rab,
                           input int len, input logic [15:0] wdata, input bit nack_first);
    exp_q = {};
    exp_q.push_back(OP_ST);
    exp_tx_byte({dev, 1'b0});
    if (!nack_first) begin
      for (int b = rab - 1; b >= 0; b--) exp_tx_byte(regv[8*b +: 8]);
      if (len > 0 && !rnw) begin
        for (int b = len - 1; b >= 0; b--) exp_tx_byte(wdata[8*b +: 8]);
      end
      if (len > 0 && rnw) begin
        exp_q.push_back(OP_RS);
        exp_tx_byte({dev, 1'b1});
        for (int b = 0; b < len; b++) begin
          for (int i = 0; i < 8; i++) exp_q.push_back(OP_RX);
          exp_q.push_back((b == len - 1) ? OP_TX1 : OP_TX0);
        end
      end
    end
    exp_q.push_back(OP_SP);
  endtask

  function automatic int first_mismatch();
    int n;
    n = (ops_q.size() < exp_q.size()) ? ops_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (ops_q[i] != exp_q[i]) return i;
    if (ops_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic drive_ready(input bit w, input logic v);
    if (w) if_b.op_ready_i = v;
    else   if_a.op_ready_i = v;
  endtask

  task automatic drive_res(input bit w, input logic v, input logic b);
    if (w) begin if_b.res_valid_i = v; if_b.res_bit_i = b; end
    else   begin if_a.res_valid_i = v; if_a.res_bit_i = b; end
  endtask

  task automatic send_cmd(input bit w, input logic rnw, input logic [6:0] dev, input logic [31:0] regv,
                          input logic [1:0] len, input logic [15:0] wdata);
    @(negedge clk);
    if (w) begin
      if_b.cmd_valid_i = 1'b1; if_b.cmd_rnw_i = rnw; if_b.cmd_dev_addr_i = dev;
      if_b.cmd_reg_addr_i = regv[7:0]; if_b.cmd_len_i = len; if_b.cmd_wdata_i = wdata;
    end else begin
      if_a.cmd_valid_i = 1'b1; if_a.cmd_rnw_i = rnw; if_a.cmd_dev_addr_i = dev;
      if_a.cmd_reg_addr_i = regv[15:0]; if_a.cmd_len_i = len; if_a.cmd_wdata_i = wdata;
    end
    @(negedge clk);
    if_a.cmd_valid_i = 1'b0;
    if_b.cmd_valid_i = 1'b0;
  endtask

  // Plays the bit engine one negedge at a time; stops on rsp_valid, after stop_after ops, or at the budget.
  task automatic run_txn(input bit w, input bit rnd, input logic [15:0] rx_data, input bit nack_first,
                         input int stop_after, input int budget);
    bit waiting, sent, prev_stall, rdy, pbit;
    logic ov, rv, cr;
    logic [2:0] op, prev_op;
    int dly, rx_idx, ack_idx, sp_cyc;
    ops_q = {}; got_rsp = 0; stall_viol = 0; wait_viol = 0; rsp_lat = -1; first_ok = 0;
    waiting = 0; sent = 0; prev_stall = 0; prev_op = '0; dly = 0; rx_idx = 0; ack_idx = 0; sp_cyc = -100;
    pbit = 0; rdy_at_rsp = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (sent) begin waiting = 0; sent = 0; end
      drive_res(w, 1'b0, 1'b0);
      if (waiting) begin
        if (dly == 0) begin drive_res(w, 1'b1, pbit); sent = 1; end
        else dly--;
      end
      ov = w ? if_b.op_valid_o  : if_a.op_valid_o;
      op = w ? if_b.op_o        : if_a.op_o;
      rv = w ? if_b.rsp_valid_o : if_a.rsp_valid_o;
      cr = w ? if_b.cmd_ready_o : if_a.cmd_ready_o;
      if (cyc == 0) first_ok = (ov === 1'b1) && (op === 3'(OP_ST));
      if (waiting && ov === 1'b1) wait_viol++;
      if (prev_stall && ov === 1'b1 && op !== prev_op) stall_viol++;
      if (rv === 1'b1) begin
        got_rsp    = 1;
        rsp_lat    = cyc - sp_cyc;
        rdy_at_rsp = cr;
        got_err    = w ? if_b.rsp_error_o : if_a.rsp_error_o;
        got_rdata  = w ? if_b.rsp_rdata_o : if_a.rsp_rdata_o;
        break;
      end
      if (stop_after >= 0 && ops_q.size() >= stop_after) break;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_ready(w, rdy);
      prev_stall = (ov === 1'b1) && !rdy;
      prev_op    = op;
      if (ov === 1'b1 && rdy) begin
        ops_q.push_back(int'(op));
        if (op == 3'(OP_SP)) sp_cyc = cyc;
        if (op == 3'(OP_RX) || op == 3'(OP_RXACK)) begin
          waiting = 1;
          dly     = rnd ? int'($urandom_range(0, 5)) : 0;
          if (op == 3'(OP_RX)) begin
            pbit = (rx_idx < 16) ? rx_data[15 - rx_idx] : 1'b0;
            rx_idx++;
          end else begin
            pbit = nack_first && (ack_idx == 0);
            ack_idx++;
          end
        end
      end
      @(negedge clk);
    end
    drive_ready(w, 1'b0);
    drive_res(w, 1'b0, 1'b0);
  endtask

  task automatic check_txn(input string tag, input int exp_count, input logic exp_err, input logic [15:0] exp_rdata);
    check({tag, ".done"},      32'(got_rsp), 32'd1);
    check({tag, ".first_st"},  32'(first_ok), 32'd1);
    check({tag, ".op_count"},  32'(ops_q.size()), 32'(exp_count));
    check({tag, ".op_stream"}, 32'(first_mismatch()), 32'hFFFF_FFFF);
    check({tag, ".error"},     32'(got_err), 32'(exp_err));
    check({tag, ".rdata"},     32'(got_rdata), 32'(exp_rdata));
    check({tag, ".rsp_lat"},   32'(rsp_lat), 32'd1);
    check({tag, ".idle_rsp"},  32'(rdy_at_rsp), 32'd1);
    check({tag, ".stable"},    32'(stall_viol), 32'd0);
    check({tag, ".wait_res"},  32'(wait_viol), 32'd0);
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    if_a.cmd_valid_i = 0; if_a.cmd_rnw_i = 0; if_a.cmd_dev_addr_i = '0; if_a.cmd_reg_addr_i = '0;
    if_a.cmd_len_i = '0; if_a.cmd_wdata_i = '0; if_a.op_ready_i = 0; if_a.res_valid_i = 0; if_a.res_bit_i = 0;
    if_b.cmd_valid_i = 0; if_b.cmd_rnw_i = 0; if_b.cmd_dev_addr_i = '0; if_b.cmd_reg_addr_i = '0;
    if_b.cmd_len_i = '0; if_b.cmd_wdata_i = '0; if_b.op_ready_i = 0; if_b.res_valid_i = 0; if_b.res_bit_i = 0;

    repeat (2) @(negedge clk);
    check("rst.op_valid",  32'(if_a.op_valid_o),  32'd0);
    check("rst.cmd_ready", 32'(if_a.cmd_ready_o), 32'd1);
    check("rst.rsp_valid", 32'(if_a.rsp_valid_o), 32'd0);
    check("rst.rsp_error", 32'(if_a.rsp_error_o), 32'd0);
    check("rst.rdata",     32'(if_a.rsp_rdata_o), 32'd0);
    check("rst.b_ready",   32'(if_b.cmd_ready_o), 32'd1);
    rst_n = 1'b1;

    // Write dev 0x0A reg 0x0002, two payload bytes A5 F0: 2+9*(1+2+2) = 47 ops.
    build_exp(0, 7'h0A, 32'h0002, 2, 2, 16'hA5F0, 0);
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd2, 16'hA5F0);
    run_txn(0, 0, 16'h0000, 0, -1, 500);
    check_txn("wr", 47, 1'b0, 16'h0000);

    // Read dev 0x0A reg 0x0100, two bytes 0x12 0x34: 3+9*(2+2+2) = 57 ops.
    build_exp(1, 7'h0A, 32'h0100, 2, 2, 16'h0000, 0);
    send_cmd(0, 1'b1, 7'h0A, 32'h0100, 2'd2, 16'h0000);
    run_txn(0, 0, 16'h1234, 0, -1, 500);
    check_txn("rd", 57, 1'b0, 16'h1234);

    // NACK on the device-address byte: ST, 8 address bits, RX_ACK, SP.
    build_exp(0, 7'h0A, 32'h0002, 2, 2, 16'hA5F0, 1);
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd2, 16'hA5F0);
    run_txn(0, 0, 16'h0000, 1, -1, 500);
    check_txn("nack", 11, 1'b1, 16'h0000);
    @(negedge clk);
    check("nack.pulse_1cyc", 32'(if_a.rsp_valid_o), 32'd0);
    check("nack.err_held",   32'(if_a.rsp_error_o), 32'd1);

    // One register byte (ADS7830 style): read dev 0x48 cmd 0x8C, one byte 0xC3: 3+9*(2+1+1) = 39 ops.
    build_exp(1, 7'h48, 32'h008C, 1, 1, 16'h0000, 0);
    send_cmd(1, 1'b1, 7'h48, 32'h008C, 2'd1, 16'h0000);
    run_txn(1, 0, 16'hC300, 0, -1, 500);
    check_txn("rd1", 39, 1'b0, 16'h00C3);

    // Pointer-only read (L=0): no repeated start, 2+9*(1+2) = 29 ops, zero data.
    build_exp(1, 7'h0A, 32'h0100, 2, 0, 16'h0000, 0);
    send_cmd(0, 1'b1, 7'h0A, 32'h0100, 2'd0, 16'h0000);
    run_txn(0, 0, 16'hFFFF, 0, -1, 500);
    check_txn("rd0", 29, 1'b0, 16'h0000);

    // Length 3 is clamped to 2: stream identical to the first write.
    build_exp(0, 7'h0A, 32'h0002, 2, 2, 16'hA5F0, 0);
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd3, 16'hA5F0);
    run_txn(0, 0, 16'h0000, 0, -1, 500);
    check_txn("clamp", 47, 1'b0, 16'h0000);

    // Same write with random op_ready and 0..5 cycle result delays.
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd2, 16'hA5F0);
    run_txn(0, 1, 16'h0000, 0, -1, 3000);
    check_txn("wr_rnd", 47, 1'b0, 16'h0000);

    // Reset in the register phase, then a clean write.
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd2, 16'hA5F0);
    run_txn(0, 0, 16'h0000, 0, 12, 500);
    check("rst_mid.ops_before", 32'(ops_q.size()), 32'd12);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.op_valid",  32'(if_a.op_valid_o),  32'd0);
    check("rst_mid.cmd_ready", 32'(if_a.cmd_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send_cmd(0, 1'b0, 7'h0A, 32'h0002, 2'd2, 16'hA5F0);
    run_txn(0, 0, 16'h0000, 0, -1, 500);
    check_txn("post_rst", 47, 1'b0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
